seq_detect_ctrl: RTL and testbench

//  Sequencer for the four1s_four0s serial detector: clears it, shifts a loaded test word into its w input
//  one bit per advance (free-run or single-step), samples z after each bit, and reports match count and

---
 rtl/seq_ctrl_pkg.sv | 20 ++
 rtl/edge_detect_rise.sv | 24 ++
 rtl/seq_detect_ctrl.sv | 136 +++++++++++++
 tb/tb_seq_detect_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the four1s_four0s sequencer: default sizes and FSM state encoding.
package seq_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_LEN_W = 5;
  localparam int DEF_CNT_W = 5;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CLR   = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN   = 3'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

  // CLR, RUN and DRAIN form the active part of a run.
  function automatic logic is_busy_state(input logic [ST_W-1:0] st);
    return (st == ST_CLR) || (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector: o_pulse is high for one cycle after i_sig goes 0 -> 1.
module edge_detect_rise (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_sig;
      r_pulse <= i_sig & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequencer that clears the serial detector, shifts a test word into it MSB first and
// collects the match count and first match index from its Moore output.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_det_w,
  output logic             o_det_en,
  output logic             o_det_rst,
  input  logic             i_det_z,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic [LEN_W-1:0] o_first_idx,
  output logic             o_first_valid,
  output logic [ST_W-1:0]  o_state
);

  // Detector handshake: det_en is a one-cycle advance strobe carrying det_w; det_z reflects
  // that advance on the following cycle, which is when r_pend asks for it to be sampled.

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_nxt;
  logic [WIDTH-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_pend_idx;
  logic [LEN_W-1:0] r_first_idx;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_pend;
  logic             r_first_valid;
  logic             r_det_w;
  logic             r_det_rst;

  logic             w_step_pulse;
  logic             w_start_ok;
  logic             w_advance;
  logic             w_last_adv;
  logic             w_bit;
  logic [WIDTH-1:0] w_shifted;
  logic [LEN_W-1:0] w_len_clamped;

  edge_detect_rise u_step_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sig   (i_step),
    .o_pulse (w_step_pulse)
  );

  assign w_start_ok    = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_len_clamped = (i_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : i_len;
  assign w_advance     = (r_state == ST_RUN) && (!i_step_mode || w_step_pulse);
  assign w_last_adv    = w_advance && (r_idx == (r_len - LEN_W'(1)));

  // Bit idx counted from the MSB, selected by shifting it into the top position.
  assign w_shifted = r_pattern << r_idx;
  assign w_bit     = w_shifted[WIDTH-1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_CLR;
      ST_CLR:   w_state_nxt = (r_len == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (w_last_adv) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = i_start ? ST_CLR : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_pattern     <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_pend        <= 1'b0;
      r_pend_idx    <= '0;
      r_match_cnt   <= '0;
      r_first_idx   <= '0;
      r_first_valid <= 1'b0;
      r_det_w       <= 1'b0;
      r_det_rst     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Registered from the next state so the detector sees reset for exactly the CLR cycle.
      r_det_rst <= (w_state_nxt != ST_CLR);

      r_pend <= w_advance;
      if (w_advance) begin
        r_det_w    <= w_bit;
        r_idx      <= r_idx + LEN_W'(1);
        r_pend_idx <= r_idx;
      end

      if (r_pend && i_det_z) begin
        if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + CNT_W'(1);
        if (!r_first_valid) begin
          r_first_idx   <= r_pend_idx;
          r_first_valid <= 1'b1;
        end
      end

      if (w_start_ok) begin
        r_pattern     <= i_pattern;
        r_len         <= w_len_clamped;
        r_idx         <= '0;
        r_match_cnt   <= '0;
        r_first_idx   <= '0;
        r_first_valid <= 1'b0;
      end
    end
  end

  // det_w follows the bit being sent on an advance and otherwise holds the last one sent.
  assign o_det_w       = w_advance ? w_bit : r_det_w;
  assign o_det_en      = w_advance;
  assign o_det_rst     = r_det_rst;
  assign o_busy        = is_busy_state(r_state);
  assign o_done        = (r_state == ST_DONE);
  assign o_match_cnt   = r_match_cnt;
  assign o_first_idx   = r_first_idx;
  assign o_first_valid = r_first_valid;
  assign o_state       = r_state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl with a behavioural four1s_four0s detector attached to its det_* port.
module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic        det_w, det_en, det_rst, det_z;
  logic        busy, done, first_valid;
  logic [4:0]  match_cnt, first_idx;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_en = 0;
  int done_cyc = 0;
  logic [31:0] en_bits = '0;

  logic [0:0] exp_q[$];
  int exp_cnt_q[$];
  int exp_first_q[$];
  int exp_fv_q[$];

  seq_detect_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_step_mode   (step_mode),
    .i_step        (step),
    .i_pattern     (pattern),
    .i_len         (len),
    .o_det_w       (det_w),
    .o_det_en      (det_en),
    .o_det_rst     (det_rst),
    .i_det_z       (det_z),
    .o_busy        (busy),
    .o_done        (done),
    .o_match_cnt   (match_cnt),
    .o_first_idx   (first_idx),
    .o_first_valid (first_valid),
    .o_state       (state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // four1s_four0s detector: z=1 once the last four accepted bits are all equal
  logic [3:0] det_hist;
  logic [1:0] det_seen;
  always @(posedge clk) begin
    if (!det_rst) begin
      det_hist <= '0;
      det_seen <= '0;
      det_z    <= 1'b0;
    end else if (det_en) begin
      det_hist <= {det_hist[2:0], det_w};
      det_seen <= (det_seen == 2'd3) ? 2'd3 : det_seen + 2'd1;
      det_z    <= (det_seen == 2'd3) &&
                  (({det_hist[2:0], det_w} == 4'hF) || ({det_hist[2:0], det_w} == 4'h0));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: bit i goes out MSB first; a match after bit i needs bits i-3..i all equal
  task automatic push_run(input logic [15:0] pat, input int ln, output int cl);
    logic [15:0] s;
    int cnt, first, fv;
    cl = (ln > 16) ? 16 : ln;
    cnt = 0; first = 0; fv = 0;
    for (int i = 0; i < cl; i++) begin
      s = pat << i;
      exp_q.push_back(s[15]);
      if (i >= 3) begin
        s = pat << (i - 3);
        if ((s[15:12] == 4'hF) || (s[15:12] == 4'h0)) begin
          if (cnt < 31) cnt++;
          if (fv == 0) begin first = i; fv = 1; end
        end
      end
    end
    exp_cnt_q.push_back(cnt);
    exp_first_q.push_back(first);
    exp_fv_q.push_back(fv);
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    logic [0:0] e;
    if (det_en) begin
      n_en++;
      en_bits = {en_bits[30:0], det_w};
      chk("det_en_with_det_rst", det_rst, 1);
      chk("det_en_busy", busy, 1);
      if (exp_q.size() == 0) chk("det_en_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("det_w", det_w, e);
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      chk("done_busy", busy, 0);
      chk("bits_pending", exp_q.size(), 0);
      if (exp_cnt_q.size() == 0) chk("done_extra", 1, 0);
      else begin
        chk("match_cnt", match_cnt, exp_cnt_q.pop_front());
        chk("first_idx", first_idx, exp_first_q.pop_front());
        chk("first_valid", first_valid, exp_fv_q.pop_front());
      end
    end
  end

  // driver: one run; returns start-edge-to-done latency in cycles
  task automatic run(input logic [15:0] pat, input int ln, input bit smode,
                     input int hmin, input int hmax, input int sw_after,
                     input bit noise, output int lat);
    int cl, j, c0, d0, jn;
    push_run(pat, ln, cl);
    d0 = n_done;
    jn = $urandom_range(cl + 1, 1);
    pattern = pat; len = 5'(ln); step_mode = smode; start = 1'b1;
    tick();
    start = 1'b0; c0 = cyc; j = 1;
    if (smode) begin
      for (int e = 0; e < cl; e++) begin
        if (e == sw_after) begin
          step_mode = 1'b0;
          break;
        end
        step = 1'b1;
        repeat ($urandom_range(hmax, hmin)) begin tick(); j++; end
        step = 1'b0;
        repeat ($urandom_range(hmax, hmin)) begin tick(); j++; end
      end
    end
    while (n_done == d0 && j < 400) begin
      if (noise && !smode && j == jn) begin
        start = 1'b1; pattern = 16'($urandom); len = 5'($urandom_range(31, 0));
      end
      tick(); j++;
      start = 1'b0;
    end
    if (n_done == d0) chk("done_timeout", 0, 1);
    lat = done_cyc - c0 + 1;
  endtask

  initial begin
    int lat, cl, j, nd, last_j, d0;
    logic [15:0] rp;
    int rl;
    bit rm, rn;

    // reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det_en", det_en, 0);
    chk("rst_det_rst", det_rst, 0);
    chk("rst_det_w", det_w, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_first_valid", first_valid, 0);
    rst = 1'b1;
    tick();
    chk("idle_det_rst", det_rst, 1);

    // 1: F000 free-run
    run(16'hF000, 16, 1'b0, 1, 1, 99, 1'b0, lat);
    chk("t1_latency", lat, 19);
    chk("t1_match_cnt", match_cnt, 10);
    chk("t1_first_idx", first_idx, 3);
    chk("t1_first_valid", first_valid, 1);

    // 2: AAAA never matches
    d0 = n_done;
    run(16'hAAAA, 16, 1'b0, 1, 1, 99, 1'b0, lat);
    repeat (3) tick();
    chk("t2_match_cnt", match_cnt, 0);
    chk("t2_first_valid", first_valid, 0);
    chk("t2_done_pulses", n_done - d0, 1);
    chk("t2_busy_after", busy, 0);

    // 3: single-step, each step level held 3 cycles
    n_en = 0; en_bits = '0;
    run(16'hF000, 4, 1'b1, 3, 3, 99, 1'b0, lat);
    chk("t3_det_en_pulses", n_en, 4);
    chk("t3_det_w_bits", int'(en_bits[3:0]), 15);
    chk("t3_match_cnt", match_cnt, 1);
    chk("t3_first_idx", first_idx, 3);

    // 4: len=0
    n_en = 0;
    run(16'hFFFF, 0, 1'b0, 1, 1, 99, 1'b0, lat);
    chk("t4_latency", lat, 3);
    chk("t4_det_en_pulses", n_en, 0);
    chk("t4_match_cnt", match_cnt, 0);

    // 5: reset at idx=5, then rerun
    push_run(16'hF000, 16, cl);
    pattern = 16'hF000; len = 5'd16; step_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("t5_idx5_det_en", det_en, 1);
    rst = 1'b0;
    tick();
    exp_q.delete(); exp_cnt_q.delete(); exp_first_q.delete(); exp_fv_q.delete();
    chk("t5_busy", busy, 0);
    chk("t5_det_en", det_en, 0);
    chk("t5_det_rst", det_rst, 0);
    chk("t5_det_w", det_w, 0);
    chk("t5_match_cnt", match_cnt, 0);
    chk("t5_first_valid", first_valid, 0);
    chk("t5_first_idx", first_idx, 0);
    rst = 1'b1;
    tick();
    run(16'hF000, 16, 1'b0, 1, 1, 99, 1'b0, lat);
    chk("t5_rerun_latency", lat, 19);
    chk("t5_rerun_match_cnt", match_cnt, 10);

    // 6: start held high, len clamps to 16, three back-to-back runs
    push_run(16'h0000, 20, cl);
    pattern = 16'h0000; len = 5'd20; start = 1'b1;
    nd = 0; j = 0; last_j = 0;
    while (nd < 3 && j < 200) begin
      tick(); j++;
      if (done) begin
        nd++;
        chk("t6_done_period", j - last_j, 19);
        last_j = j;
        if (nd == 3) start = 1'b0;
        @(negedge clk); #1;
        if (nd < 3) push_run(16'h0000, 20, cl);
      end
    end
    if (nd < 3) chk("t6_timeout", nd, 3);
    chk("t6_match_cnt", match_cnt, 13);
    chk("t6_first_idx", first_idx, 3);
    repeat (2) tick();
    chk("t6_idle_after", busy, 0);

    // randomized runs, with ignored starts and mode switches mixed in
    for (int r = 0; r < 24; r++) begin
      rp = 16'($urandom);
      if (r % 4 == 0) rp = {4{4'($urandom)}};
      rl = $urandom_range(20, 0);
      rm = 1'($urandom_range(1, 0));
      rn = 1'($urandom_range(1, 0));
      run(rp, rl, rm, 1, 3, $urandom_range(20, 0), rn, lat);
      if (!rm) chk("rand_latency", lat, ((rl > 16) ? 16 : rl) + 3);
      repeat ($urandom_range(2, 0)) tick();
    end

    repeat (3) tick();
    chk("end_queue_empty", exp_q.size() + exp_cnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
